rdft_bin_capture: RTL and testbench

- Downstream stage of the recursive DFT bin datapath.
- Watches the bin's complex running output every clock, counts samples, and latches the bin value on the last sample of each N-sample frame.
- Computes scaled power, queues {bin index, re, im, power} in a small FIFO with a valid/ready output, and pulses frame_done to clear the bin accumulator for the next frame.

---
 rtl/rdft_pkg.sv | 28 ++
 rtl/rdft_res_fifo.sv | 49 ++++
 rtl/rdft_bin_capture.sv | 141 ++++++++++++++
 tb/tb_rdft_bin_capture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rdft_pkg.sv
// Shared constants, result record and helpers for the recursive DFT bin capture stage.
package rdft_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned N_DEF     = 53;
  localparam int unsigned SCALE_DEF = 1000000;
  localparam int unsigned NBINS_DEF = 53;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned PW_DEF    = 2 * DW_DEF;
  localparam int unsigned BW_DEF    = clog2(NBINS_DEF);

  typedef struct packed {
    logic [BW_DEF-1:0]        bin;
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
    logic [PW_DEF-1:0]        pwr;
  } rdft_res_t;

endpackage

// File: rtl/rdft_res_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is taken only when a pop happens on the same edge.
module rdft_res_fifo
  import rdft_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  always_comb begin
    empty_c = (wptr == rptr);
    full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop  = pop && !empty_c;
    do_push = push && (!full_c || do_pop);
    rdata_c = empty_c ? '0 : mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the read port is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rdft_bin_capture.sv
// Counts bin output samples, latches the bin value at frame end, computes scaled power
// and queues {bin, re, im, pwr} for a valid/ready consumer.
module rdft_bin_capture
  import rdft_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned SCALE = SCALE_DEF,
  parameter int unsigned NBINS = NBINS_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PW    = 2 * DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [DW-1:0]       outData,
  input  logic signed [DW-1:0]       j_outData,
  input  logic                       sync_clr,
  output logic                       frame_done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [clog2(NBINS)-1:0]    res_bin,
  output logic signed [DW-1:0]       res_re,
  output logic signed [DW-1:0]       res_im,
  output logic [PW-1:0]              res_pwr,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned CW = clog2(N);
  localparam int unsigned BW = clog2(NBINS);
  localparam int unsigned PD = 2 * DW;
  localparam int unsigned SW = 2 * DW + 1;
  localparam int unsigned FW = BW + 2 * DW + PW;

  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bin;

  logic                 s1_valid;
  logic [BW-1:0]        s1_bin;
  logic signed [DW-1:0] s1_re;
  logic signed [DW-1:0] s1_im;

  logic                 s2_valid;
  logic [BW-1:0]        s2_bin;
  logic signed [DW-1:0] s2_re;
  logic signed [DW-1:0] s2_im;
  logic [PW-1:0]        s2_pwr;

  logic signed [PD-1:0] re_sq;
  logic signed [PD-1:0] im_sq;
  logic [SW-1:0]        pwr_sum;
  logic [SW-1:0]        pwr_quo;
  logic [PW-1:0]        pwr_sat_c;

  logic [FW-1:0]        fifo_rdata_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic                 drop_c;

  // Squares are non-negative, so the sum is exact in 2*DW+1 unsigned bits.
  always_comb begin
    re_sq     = PD'(s1_re) * PD'(s1_re);
    im_sq     = PD'(s1_im) * PD'(s1_im);
    pwr_sum   = SW'($unsigned(re_sq)) + SW'($unsigned(im_sq));
    pwr_quo   = pwr_sum / SW'(SCALE);
    pwr_sat_c = (|pwr_quo[SW-1:PW]) ? '1 : pwr_quo[PW-1:0];
  end

  assign drop_c = s2_valid && fifo_full_c && !(res_ready && !fifo_empty_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      bin        <= '0;
      frame_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_bin     <= '0;
      s1_re      <= '0;
      s1_im      <= '0;
      s2_valid   <= 1'b0;
      s2_bin     <= '0;
      s2_re      <= '0;
      s2_im      <= '0;
      s2_pwr     <= '0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      s1_valid   <= 1'b0;
      // Realign wins over a sample arriving in the same cycle.
      if (sync_clr) begin
        cnt <= '0;
        bin <= '0;
      end else if (in_valid) begin
        if (cnt == CW'(N - 1)) begin
          cnt        <= '0;
          bin        <= (bin == BW'(NBINS - 1)) ? '0 : bin + BW'(1);
          s1_valid   <= 1'b1;
          s1_bin     <= bin;
          s1_re      <= outData;
          s1_im      <= j_outData;
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin <= s1_bin;
        s2_re  <= s1_re;
        s2_im  <= s1_im;
        s2_pwr <= pwr_sat_c;
      end

      if (drop_c) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  rdft_res_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (s2_valid),
    .wdata   ({s2_bin, s2_re, s2_im, s2_pwr}),
    .pop     (res_ready),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign res_valid = !fifo_empty_c;
  assign {res_bin, res_re, res_im, res_pwr} = fifo_rdata_c;

endmodule

// File: tb/tb_rdft_bin_capture.sv
// Directed bench for rdft_bin_capture with hand-computed expected values.
module tb_rdft_bin_capture;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [31:0] outData;
  logic signed [31:0] j_outData;
  logic               sync_clr;
  logic               frame_done;
  logic               res_valid;
  logic               res_ready;
  logic [5:0]         res_bin;
  logic signed [31:0] res_re;
  logic signed [31:0] res_im;
  logic [63:0]        res_pwr;
  logic               ovf;
  logic [7:0]         drop_cnt;

  int n_vec;
  int n_bad;
  bit fd_seen;

  rdft_bin_capture dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .outData    (outData),
    .j_outData  (j_outData),
    .sync_clr   (sync_clr),
    .frame_done (frame_done),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_bin    (res_bin),
    .res_re     (res_re),
    .res_im     (res_im),
    .res_pwr    (res_pwr),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic v, input logic signed [31:0] re, input logic signed [31:0] im);
    in_valid  = v;
    outData   = re;
    j_outData = im;
    @(posedge clk);
    #1;
    if (frame_done) fd_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'sd0, 32'sd0);
  endtask

  // 52 filler samples (never latched) followed by the frame's last sample.
  task automatic frame(input logic signed [31:0] re, input logic signed [31:0] im);
    for (int i = 0; i < 52; i++) step(1'b1, 32'(i + 7), -32'(i + 3));
    step(1'b1, re, im);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    fd_seen   = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    outData   = '0;
    j_outData = '0;
    sync_clr  = 1'b0;
    res_ready = 1'b0;

    // Reset state
    idle(2);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_fd", 64'(frame_done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_re", 64'(res_re), 64'd0);
    check("rst_pwr", res_pwr, 64'd0);
    rst = 1'b1;

    // Basic capture: 3e6 + j4e6
    fd_seen = 1'b0;
    for (int i = 0; i < 52; i++) step(1'b1, 32'(i + 7), -32'(i + 3));
    check("t1_no_early_fd", 64'(fd_seen), 64'd0);
    step(1'b1, 32'sd3000000, 32'sd4000000);
    check("t1_fd", 64'(frame_done), 64'd1);
    check("t1_valid_k", 64'(res_valid), 64'd0);
    idle(1);
    check("t1_fd_pulse", 64'(frame_done), 64'd0);
    check("t1_valid_k1", 64'(res_valid), 64'd0);
    idle(1);
    check("t1_valid_k2", 64'(res_valid), 64'd1);
    check("t1_bin", 64'(res_bin), 64'd0);
    check("t1_re", 64'(res_re), 64'(32'sd3000000));
    check("t1_im", 64'(res_im), 64'(32'sd4000000));
    check("t1_pwr", res_pwr, 64'd25000000);
    idle(1);
    check("t1_hold", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    idle(1);
    check("t1_pop", 64'(res_valid), 64'd0);

    // Negative components with continuous ready
    frame(-32'sd2000000, -32'sd1000000);
    idle(2);
    check("t2_valid", 64'(res_valid), 64'd1);
    check("t2_bin", 64'(res_bin), 64'd1);
    check("t2_re", 64'(res_re), 64'(-32'sd2000000));
    check("t2_im", 64'(res_im), 64'(-32'sd1000000));
    check("t2_pwr", res_pwr, 64'd5000000);
    idle(1);
    check("t2_single", 64'(res_valid), 64'd0);

    // Overflow: six frames into a depth-4 FIFO with no consumer
    res_ready = 1'b0;
    do_reset();
    for (int f = 0; f < 6; f++) frame(32'(1000 * (f + 1)), 32'sd0);
    idle(2);
    check("t3_ovf", 64'(ovf), 64'd1);
    check("t3_drop", 64'(drop_cnt), 64'd2);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_valid", 64'(res_valid), 64'd1);
      check("t3_drain_bin", 64'(res_bin), 64'(i));
      check("t3_drain_re", 64'(res_re), 64'(32'(1000 * (i + 1))));
      check("t3_drain_pwr", res_pwr, 64'((i + 1) * (i + 1)));
      idle(1);
    end
    check("t3_empty", 64'(res_valid), 64'd0);

    // Full FIFO, pop on the same edge as the pending write
    res_ready = 1'b0;
    do_reset();
    for (int f = 0; f < 4; f++) frame(32'(100 * (f + 1)), 32'sd0);
    idle(2);
    frame(32'sd500, 32'sd0);
    idle(1);
    res_ready = 1'b1;
    idle(1);
    res_ready = 1'b0;
    check("t4_ovf", 64'(ovf), 64'd0);
    check("t4_drop", 64'(drop_cnt), 64'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_occ_bin", 64'(res_bin), 64'(i + 1));
      check("t4_occ_re", 64'(res_re), 64'(32'(100 * (i + 2))));
      idle(1);
    end
    check("t4_empty", 64'(res_valid), 64'd0);

    // 50% in_valid duty, then sync_clr realign at cnt=20
    do_reset();
    fd_seen = 1'b0;
    for (int i = 0; i < 52; i++) begin
      step(1'b1, 32'sd9, 32'sd9);
      step(1'b0, 32'sd1, 32'sd1);
    end
    check("t5_gap_no_fd", 64'(fd_seen), 64'd0);
    step(1'b1, 32'sd111, 32'sd222);
    check("t5_gap_fd", 64'(frame_done), 64'd1);
    idle(4);
    check("t5_drained", 64'(res_valid), 64'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'sd5, 32'sd5);
    sync_clr = 1'b1;
    step(1'b1, 32'sd5, 32'sd5);
    sync_clr = 1'b0;
    fd_seen = 1'b0;
    for (int i = 0; i < 52; i++) step(1'b1, 32'(i + 7), 32'sd0);
    check("t5_clr_no_fd", 64'(fd_seen), 64'd0);
    step(1'b1, 32'sd5000, 32'sd0);
    check("t5_clr_fd", 64'(frame_done), 64'd1);
    res_ready = 1'b0;
    idle(2);
    check("t5_clr_valid", 64'(res_valid), 64'd1);
    check("t5_clr_bin", 64'(res_bin), 64'd0);
    check("t5_clr_re", 64'(res_re), 64'(32'sd5000));

    // Async reset with an entry queued and a frame just latched
    do_reset();
    frame(32'sd7000, 32'sd0);
    idle(2);
    frame(32'sd8000, 32'sd0);
    rst = 1'b0;
    #1;
    check("t6_rst_fd", 64'(frame_done), 64'd0);
    check("t6_rst_valid", 64'(res_valid), 64'd0);
    check("t6_rst_re", 64'(res_re), 64'd0);
    idle(2);
    rst = 1'b1;
    // Partial frame to cnt=40, then reset again
    for (int i = 0; i < 40; i++) step(1'b1, 32'sd3, 32'sd3);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(3);
    check("t6_no_stale", 64'(res_valid), 64'd0);
    fd_seen = 1'b0;
    for (int i = 0; i < 52; i++) step(1'b1, 32'(i + 7), 32'sd0);
    check("t6_full_frame", 64'(fd_seen), 64'd0);
    step(1'b1, 32'sd9000, -32'sd12000);
    check("t6_fd", 64'(frame_done), 64'd1);
    idle(2);
    check("t6_valid", 64'(res_valid), 64'd1);
    check("t6_bin", 64'(res_bin), 64'd0);
    check("t6_im", 64'(res_im), 64'(-32'sd12000));
    check("t6_pwr", res_pwr, 64'd225);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
